// File: rtl/centroid_pkg.sv
// Shared types and default widths for the centroid moment accumulator.
package centroid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEF_X_W   = 11;
    localparam int DEF_Y_W   = 11;
    localparam int DEF_SUM_W = 32;
    localparam int DEF_CNT_W = 22;

endpackage

// File: rtl/sat_accu.sv
// Single unsigned accumulator with synchronous clear, sticky carry-out flag
// and selectable saturate/wrap behaviour.
module sat_accu #(
    parameter int W    = 32,
    parameter int IN_W = 11,
    parameter int SAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] a,
    output logic [W-1:0]    y,
    output logic            ovf
);

    // Returns {carry, next value}; a clamped accumulator stays clamped
    // because any further non-zero add carries out again.
    function automatic logic [W:0] add_sat(input logic [W-1:0] acc,
                                           input logic [IN_W-1:0] inc);
        logic [W:0] sum;
        sum = {1'b0, acc} + (W+1)'(inc);
        if (sum[W] && (SAT != 0))
            return {1'b1, {W{1'b1}}};
        return sum;
    endfunction

    logic [W:0] nxt;

    always_comb begin
        nxt = add_sat(y, a);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                y   <= '0;
                ovf <= 1'b0;
            end else if (en) begin
                y   <= nxt[W-1:0];
                ovf <= ovf | nxt[W];
            end
        end
    end

endmodule

// File: rtl/centroid_moments_accu.sv
// Per-frame accumulation of object pixel count, sum of x and sum of y,
// published as a registered snapshot two cycles after frame_end.
module centroid_moments_accu
    import centroid_pkg::*;
#(
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int SUM_W = DEF_SUM_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             de,
    input  logic             mask,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output logic [SUM_W-1:0] sum_x,
    output logic [SUM_W-1:0] sum_y,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             result_valid
);

    state_t state, state_next;
    logic   window_open;
    logic   clr;

    logic           hit_p1;
    logic [X_W-1:0] x_p1;
    logic [Y_W-1:0] y_p1;
    logic           done_p2;

    logic [SUM_W-1:0] acc_x, acc_y;
    logic [CNT_W-1:0] acc_c;
    logic             ovf_x, ovf_y, ovf_c;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else if (ce)
            state <= state_next;
    end

    // A restart clears the accumulators, which also drops whatever stage 1
    // was holding from before the restart.
    always_comb begin
        state_next  = state;
        window_open = (state == ACCUM) | frame_start;
        clr         = done_p2;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = ACCUM;
                    clr        = 1'b1;
                end
            end
            ACCUM: begin
                if (frame_end)
                    state_next = FLUSH;
                else if (frame_start)
                    clr = 1'b1;
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: qualify and register the incoming pixel
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_p1 <= 1'b0;
            x_p1   <= '0;
            y_p1   <= '0;
        end else if (ce) begin
            hit_p1 <= de & mask & window_open;
            x_p1   <= x;
            y_p1   <= y;
        end
    end

    // Stage 2: accumulate
    sat_accu #(.W(SUM_W), .IN_W(X_W), .SAT(SAT)) u_acc_x (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .en(hit_p1),
        .a(x_p1), .y(acc_x), .ovf(ovf_x)
    );

    sat_accu #(.W(SUM_W), .IN_W(Y_W), .SAT(SAT)) u_acc_y (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .en(hit_p1),
        .a(y_p1), .y(acc_y), .ovf(ovf_y)
    );

    sat_accu #(.W(CNT_W), .IN_W(1), .SAT(SAT)) u_acc_c (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .en(hit_p1),
        .a(1'b1), .y(acc_c), .ovf(ovf_c)
    );

    // Output snapshot: taken the edge after FLUSH drained stage 1
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_p2      <= 1'b0;
            sum_x        <= '0;
            sum_y        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else if (ce) begin
            done_p2      <= (state == FLUSH);
            result_valid <= done_p2;
            if (done_p2) begin
                sum_x    <= acc_x;
                sum_y    <= acc_y;
                count    <= acc_c;
                overflow <= ovf_x | ovf_y | ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_centroid_moments_accu.sv
// Randomised and directed bench for centroid_moments_accu; three instances
// (32-bit saturating, 16-bit saturating, 16-bit wrapping) share one stimulus.
module tb_centroid_moments_accu;

    logic        clk = 1'b0;
    logic        rst, ce, frame_start, frame_end, de, mask;
    logic [10:0] x, y;

    logic [31:0] sx0, sy0;
    logic [21:0] cnt0, cnt1, cnt2;
    logic [15:0] sx1, sy1, sx2, sy2;
    logic        ovf0, ovf1, ovf2, rv0, rv1, rv2;

    always #5 clk = ~clk;

    centroid_moments_accu #(.SUM_W(32), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start), .frame_end(frame_end),
        .de(de), .mask(mask), .x(x), .y(y), .sum_x(sx0), .sum_y(sy0), .count(cnt0),
        .overflow(ovf0), .result_valid(rv0));

    centroid_moments_accu #(.SUM_W(16), .SAT(1)) u_s16 (
        .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start), .frame_end(frame_end),
        .de(de), .mask(mask), .x(x), .y(y), .sum_x(sx1), .sum_y(sy1), .count(cnt1),
        .overflow(ovf1), .result_valid(rv1));

    centroid_moments_accu #(.SUM_W(16), .SAT(0)) u_w16 (
        .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start), .frame_end(frame_end),
        .de(de), .mask(mask), .x(x), .y(y), .sum_x(sx2), .sum_y(sy2), .count(cnt2),
        .overflow(ovf2), .result_valid(rv2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level reference: true (unbounded) moments of the current frame,
    // a snapshot taken at frame close, and a countdown in enabled edges.
    bit     m_open, m_flush, e_valid;
    longint m_cnt, m_sx, m_sy;
    longint s_cnt, s_sx, s_sy;
    longint e_cnt, e_sx, e_sy;
    int     m_cd;

    // Last published results from each instance, for directed constant checks.
    longint l_sx0, l_sy0, l_cnt0, l_ovf0, l_sx1, l_ovf1, l_sx2, l_ovf2;
    int     n_valid;

    function automatic longint lim(input longint t, input int w, input bit sat);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (t > mx) return sat ? mx : (t % (longint'(1) << w));
        return t;
    endfunction

    function automatic longint ovf_of(input int w);
        longint mx, mc;
        mx = (longint'(1) << w) - 1;
        mc = (longint'(1) << 22) - 1;
        return ((e_sx > mx) || (e_sy > mx) || (e_cnt > mc)) ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit pix;
        pix = de && mask;
        if (!rst) begin
            m_open = 0; m_flush = 0; m_cd = 0; e_valid = 0;
            m_cnt = 0; m_sx = 0; m_sy = 0;
            e_cnt = 0; e_sx = 0; e_sy = 0;
        end else if (ce) begin
            e_valid = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    e_valid = 1; e_cnt = s_cnt; e_sx = s_sx; e_sy = s_sy;
                end
            end
            if (m_flush) begin
                m_flush = 0;
            end else if (m_open) begin
                if (frame_start && !frame_end) begin
                    m_cnt = 0; m_sx = 0; m_sy = 0;
                end
                if (pix) begin m_cnt++; m_sx += x; m_sy += y; end
                if (frame_end) begin
                    s_cnt = m_cnt; s_sx = m_sx; s_sy = m_sy;
                    m_cd = 2; m_open = 0; m_flush = 1;
                end
            end else if (frame_start) begin
                m_cnt = 0; m_sx = 0; m_sy = 0;
                if (pix) begin m_cnt++; m_sx += x; m_sy += y; end
                m_open = 1;
            end
        end
    endtask

    task automatic compare();
        check("rv0", rv0, e_valid);
        check("rv1", rv1, e_valid);
        check("rv2", rv2, e_valid);
        check("sum_x0", sx0, lim(e_sx, 32, 1));
        check("sum_y0", sy0, lim(e_sy, 32, 1));
        check("count0", cnt0, lim(e_cnt, 22, 1));
        check("ovf0", ovf0, ovf_of(32));
        check("sum_x1", sx1, lim(e_sx, 16, 1));
        check("sum_y1", sy1, lim(e_sy, 16, 1));
        check("ovf1", ovf1, ovf_of(16));
        check("sum_x2", sx2, lim(e_sx, 16, 0));
        check("sum_y2", sy2, lim(e_sy, 16, 0));
        check("count2", cnt2, lim(e_cnt, 22, 0));
        check("ovf2", ovf2, ovf_of(16));
        if (rv0 && ce) begin
            n_valid++;
            l_sx0 = sx0; l_sy0 = sy0; l_cnt0 = cnt0; l_ovf0 = ovf0;
            l_sx1 = sx1; l_ovf1 = ovf1; l_sx2 = sx2; l_ovf2 = ovf2;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit fs, input bit fe,
                        input bit d, input bit m, input int xi, input int yi);
        @(negedge clk);
        rst = r; ce = c; frame_start = fs; frame_end = fe;
        de = d; mask = m; x = 11'(xi); y = 11'(yi);
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int xi, input int yi);
        step(1, 1, 0, 0, 1, 1, xi, yi);
    endtask

    initial begin
        n_valid = 0;
        rst = 0; ce = 1; frame_start = 0; frame_end = 0; de = 0; mask = 0; x = 0; y = 0;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // 2x2 object with some background pixels
        step(1, 1, 1, 0, 0, 0, 0, 0);
        pix(10, 20); pix(11, 20);
        step(1, 1, 0, 0, 1, 0, 500, 500);
        pix(10, 21);
        step(1, 1, 0, 1, 1, 1, 11, 21);
        idle(4);
        check("tp_2x2_sum_x", l_sx0, 42);
        check("tp_2x2_sum_y", l_sy0, 82);
        check("tp_2x2_count", l_cnt0, 4);
        check("tp_2x2_ovf", l_ovf0, 0);

        // 33 hits at x=2047 on the 16-bit instances
        step(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) pix(2047, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle(3);
        check("tp_sat_sum_x", l_sx1, 65535);
        check("tp_sat_ovf", l_ovf1, 1);
        check("tp_wrap_sum_x", l_sx2, 2015);
        check("tp_wrap_ovf", l_ovf2, 1);

        // pixels in IDLE ignored; pixels on start and end cycles counted
        pix(5, 5); pix(6, 6);
        step(1, 1, 1, 0, 1, 1, 3, 4);
        idle(2);
        step(1, 1, 0, 1, 1, 1, 7, 8);
        idle(3);
        check("tp_edge_count", l_cnt0, 2);
        check("tp_edge_sum_x", l_sx0, 10);

        // restart after 5 hits, then 3 hits; then start+end together closes
        step(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) pix(100 + i, 1);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) pix(1, 2);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle(3);
        check("tp_restart_count", l_cnt0, 3);
        step(1, 1, 1, 0, 1, 1, 9, 9);
        step(1, 1, 1, 1, 1, 1, 1, 1);
        idle(3);
        check("tp_both_count", l_cnt0, 2);

        // ce low across FLUSH and while valid is up
        step(1, 1, 1, 0, 0, 0, 0, 0);
        pix(20, 30); pix(21, 31);
        step(1, 1, 0, 1, 1, 1, 22, 32);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 1, 1, 99, 99);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        check("tp_ce_sum_x", l_sx0, 63);
        check("tp_ce_count", l_cnt0, 3);

        // reset mid-frame, then empty frame
        step(1, 1, 1, 0, 0, 0, 0, 0);
        pix(1, 1); pix(2, 2);
        step(0, 1, 0, 0, 1, 1, 3, 3);
        idle(3);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle(3);
        check("tp_empty_count", l_cnt0, 0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 2047)));
        end
        idle(4);
        check("valid_pulses_seen", (n_valid > 8) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
